// File: rtl/posit_packer_if.sv
// rtl/posit_packer_if.sv - field-in / posit-out handshake bundle for the posit packer
interface posit_packer_if #(
   parameter int N  = 8,
   parameter int ES = 3,
   parameter int RS = $clog2(N)
);
   logic              in_valid;
   logic              in_ready;
   logic              Sign;
   logic [RS:0]       RegimeValue;
   logic [ES-1:0]     Exponent;
   logic [N-ES+2:0]   Mantissa;
   logic              IsZero;
   logic              IsNaR;
   logic              out_valid;
   logic              out_ready;
   logic [N-1:0]      Out;

   modport master (
      output in_valid, Sign, RegimeValue, Exponent, Mantissa, IsZero, IsNaR, out_ready,
      input  in_ready, out_valid, Out
   );

   modport slave (
      input  in_valid, Sign, RegimeValue, Exponent, Mantissa, IsZero, IsNaR, out_ready,
      output in_ready, out_valid, Out
   );
endinterface

// File: rtl/posit_packer.sv
// rtl/posit_packer.sv - two-stage posit encoder: body build (S1), round/saturate/negate (S2)
module posit_packer #(
   parameter int N  = 8,
   parameter int ES = 3,
   parameter int RS = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   posit_packer_if.slave bus
);
   localparam int F   = N - ES + 2;
   localparam int PAD = 1 << RS;
   localparam int SW  = 2 + ES + F + PAD;
   localparam logic [N-2:0] MAXPOS = '1;
   localparam logic [N-2:0] MINPOS = (N-1)'(1);

   logic          s1_valid;
   logic          s1_adv;
   logic          s2_adv;
   logic          s1_sign, s1_zero, s1_nar, s1_smax, s1_smin, s1_g, s1_s;
   logic [N-2:0]  s1_mag;

   assign s2_adv      = !bus.out_valid || bus.out_ready;
   assign s1_adv      = !s1_valid || s2_adv;
   assign bus.in_ready = s1_adv;

   logic                 k_neg;
   logic [RS-1:0]        shamt;
   logic signed [SW-1:0] body_raw;
   logic signed [SW-1:0] body;
   int                   kval;
   logic [N-2:0]         b_mag;
   logic                 b_g, b_s, b_smax, b_smin;

   // {~neg, neg, E, frac} arithmetic-shifted by k (or ~k when negative) yields the
   // regime run followed by its terminator, with E and fraction trailing behind it.
   always_comb begin
      k_neg    = bus.RegimeValue[RS];
      kval     = int'($signed(bus.RegimeValue));
      shamt    = k_neg ? ~bus.RegimeValue[RS-1:0] : bus.RegimeValue[RS-1:0];
      body_raw = {~k_neg, k_neg, bus.Exponent, bus.Mantissa[F-1:0], {PAD{1'b0}}};
      body     = body_raw >>> shamt;
      b_mag    = body[SW-1 -: N-1];
      b_g      = body[SW-N];
      b_s      = |body[SW-N-1:0];
      b_smax   = kval >= N - 2;
      b_smin   = kval <= -(N - 1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_mag   <= '0;
         s1_g     <= 1'b0;
         s1_s     <= 1'b0;
         s1_sign  <= 1'b0;
         s1_zero  <= 1'b0;
         s1_nar   <= 1'b0;
         s1_smax  <= 1'b0;
         s1_smin  <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= bus.in_valid;
         s1_mag   <= b_mag;
         s1_g     <= b_g;
         s1_s     <= b_s;
         s1_sign  <= bus.Sign;
         s1_zero  <= bus.IsZero;
         s1_nar   <= bus.IsNaR;
         s1_smax  <= b_smax;
         s1_smin  <= b_smin;
      end
   end

   logic         rnd;
   logic [N-1:0] sum;
   logic [N-2:0] rmag;
   logic [N-2:0] fmag;
   logic [N-1:0] res;

   // Real results never round to zero or NaR: overflow clamps to maxpos, underflow to minpos.
   always_comb begin
      rnd  = s1_g && (s1_s || s1_mag[0]);
      sum  = {1'b0, s1_mag} + {{(N-1){1'b0}}, rnd};
      rmag = sum[N-1] ? MAXPOS : sum[N-2:0];
      if (rmag == '0) rmag = MINPOS;
      fmag = s1_smax ? MAXPOS : (s1_smin ? MINPOS : rmag);
      res  = s1_sign ? (~{1'b0, fmag} + 1'b1) : {1'b0, fmag};
      if (s1_zero) res = '0;
      if (s1_nar)  res = {1'b1, {(N-1){1'b0}}};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.Out       <= '0;
      end else if (s2_adv) begin
         bus.out_valid <= s1_valid;
         if (s1_valid) bus.Out <= res;
      end
   end
endmodule
